// File: rtl/id_ex_pipe_reg.sv
// rtl/id_ex_pipe_reg.sv - ID/EX pipeline register with hold, bubble insertion and optional IDEX_PERF_CNT_EN counters
module id_ex_pipe_reg #(
    parameter int XLEN      = 32,
    parameter int RADDR_W   = 5,
`ifdef IDEX_PERF_CNT_EN
    parameter int ALUCTRL_W = 3,
    parameter int CNT_W     = 16
`else
    parameter int ALUCTRL_W = 3
`endif
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 StallE,
    input  logic                 FlushE,
    input  logic                 ValidD,
    input  logic                 RegWriteD,
    input  logic [1:0]           ResultSrcD,
    input  logic                 MemWriteD,
    input  logic                 JumpD,
    input  logic                 BranchD,
    input  logic                 ALUSrcD,
    input  logic [ALUCTRL_W-1:0] ALUControlD,
    input  logic [XLEN-1:0]      RD1D,
    input  logic [XLEN-1:0]      RD2D,
    input  logic [XLEN-1:0]      PCD,
    input  logic [XLEN-1:0]      PCPlus4D,
    input  logic [XLEN-1:0]      ImmExtD,
    input  logic [RADDR_W-1:0]   Rs1D,
    input  logic [RADDR_W-1:0]   Rs2D,
    input  logic [RADDR_W-1:0]   RdD,
    output logic                 ValidE,
    output logic                 RegWriteE,
    output logic [1:0]           ResultSrcE,
    output logic                 MemWriteE,
    output logic                 JumpE,
    output logic                 BranchE,
    output logic                 ALUSrcE,
    output logic [ALUCTRL_W-1:0] ALUControlE,
    output logic [XLEN-1:0]      RD1E,
    output logic [XLEN-1:0]      RD2E,
    output logic [XLEN-1:0]      PCE,
    output logic [XLEN-1:0]      PCPlus4E,
    output logic [XLEN-1:0]      ImmExtE,
    output logic [RADDR_W-1:0]   Rs1E,
    output logic [RADDR_W-1:0]   Rs2E,
`ifdef IDEX_PERF_CNT_EN
    output logic [RADDR_W-1:0]   RdE,
    output logic [CNT_W-1:0]     StallCntE,
    output logic [CNT_W-1:0]     BubbleCntE
`else
    output logic [RADDR_W-1:0]   RdE
`endif
);

    // A real instruction keeps its control bundle; an invalid slot loads as a
    // bubble so nothing downstream can write state, while its data still flows.
    logic load_ctrl;
    assign load_ctrl = ValidD;

    // Control bundle: flush beats stall beats load; invalid loads become bubbles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ValidE      <= 1'b0;
            RegWriteE   <= 1'b0;
            ResultSrcE  <= 2'b00;
            MemWriteE   <= 1'b0;
            JumpE       <= 1'b0;
            BranchE     <= 1'b0;
            ALUSrcE     <= 1'b0;
            ALUControlE <= '0;
        end else if (FlushE) begin
            ValidE      <= 1'b0;
            RegWriteE   <= 1'b0;
            ResultSrcE  <= 2'b00;
            MemWriteE   <= 1'b0;
            JumpE       <= 1'b0;
            BranchE     <= 1'b0;
            ALUSrcE     <= 1'b0;
            ALUControlE <= '0;
        end else if (!StallE) begin
            if (load_ctrl) begin
                ValidE      <= 1'b1;
                RegWriteE   <= RegWriteD;
                ResultSrcE  <= ResultSrcD;
                MemWriteE   <= MemWriteD;
                JumpE       <= JumpD;
                BranchE     <= BranchD;
                ALUSrcE     <= ALUSrcD;
                ALUControlE <= ALUControlD;
            end else begin
                ValidE      <= 1'b0;
                RegWriteE   <= 1'b0;
                ResultSrcE  <= 2'b00;
                MemWriteE   <= 1'b0;
                JumpE       <= 1'b0;
                BranchE     <= 1'b0;
                ALUSrcE     <= 1'b0;
                ALUControlE <= '0;
            end
        end
    end

    // Datapath fields: zeroed on flush so a bubble is a deterministic NOP,
    // held on stall, otherwise loaded regardless of ValidD.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            RD1E     <= '0;
            RD2E     <= '0;
            PCE      <= '0;
            PCPlus4E <= '0;
            ImmExtE  <= '0;
            Rs1E     <= '0;
            Rs2E     <= '0;
            RdE      <= '0;
        end else if (FlushE) begin
            RD1E     <= '0;
            RD2E     <= '0;
            PCE      <= '0;
            PCPlus4E <= '0;
            ImmExtE  <= '0;
            Rs1E     <= '0;
            Rs2E     <= '0;
            RdE      <= '0;
        end else if (!StallE) begin
            RD1E     <= RD1D;
            RD2E     <= RD2D;
            PCE      <= PCD;
            PCPlus4E <= PCPlus4D;
            ImmExtE  <= ImmExtD;
            Rs1E     <= Rs1D;
            Rs2E     <= Rs2D;
            RdE      <= RdD;
        end
    end

`ifdef IDEX_PERF_CNT_EN
    // A bubble enters E either by explicit flush or by loading an invalid slot.
    logic stall_evt;
    logic bubble_evt;
    assign stall_evt  = StallE && !FlushE;
    assign bubble_evt = FlushE || (!StallE && !ValidD);

    // Saturating perf counters; only reset clears them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            StallCntE  <= '0;
            BubbleCntE <= '0;
        end else begin
            if (stall_evt && (StallCntE != {CNT_W{1'b1}})) begin
                StallCntE <= StallCntE + 1'b1;
            end
            if (bubble_evt && (BubbleCntE != {CNT_W{1'b1}})) begin
                BubbleCntE <= BubbleCntE + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// tb/tb_id_ex_pipe_reg.sv - directed self-checking bench for id_ex_pipe_reg
module tb_id_ex_pipe_reg;

    logic        clk;
    logic        rst_n;
    logic        StallE, FlushE, ValidD;
    logic        RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD;
    logic [1:0]  ResultSrcD;
    logic [2:0]  ALUControlD;
    logic [31:0] RD1D, RD2D, PCD, PCPlus4D, ImmExtD;
    logic [4:0]  Rs1D, Rs2D, RdD;
    logic        ValidE, RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE;
    logic [1:0]  ResultSrcE;
    logic [2:0]  ALUControlE;
    logic [31:0] RD1E, RD2E, PCE, PCPlus4E, ImmExtE;
    logic [4:0]  Rs1E, Rs2E, RdE;
`ifdef IDEX_PERF_CNT_EN
    logic [3:0]  StallCntE, BubbleCntE;
`endif

    logic [185:0] all_e;
    assign all_e = {ValidE, RegWriteE, ResultSrcE, MemWriteE, JumpE, BranchE, ALUSrcE,
                    ALUControlE, RD1E, RD2E, PCE, PCPlus4E, ImmExtE, Rs1E, Rs2E, RdE};

    int passed;
    int total;

`ifdef IDEX_PERF_CNT_EN
    id_ex_pipe_reg #(.XLEN(32), .RADDR_W(5), .ALUCTRL_W(3), .CNT_W(4)) dut (
`else
    id_ex_pipe_reg #(.XLEN(32), .RADDR_W(5), .ALUCTRL_W(3)) dut (
`endif
        .clk(clk), .rst_n(rst_n), .StallE(StallE), .FlushE(FlushE), .ValidD(ValidD),
        .RegWriteD(RegWriteD), .ResultSrcD(ResultSrcD), .MemWriteD(MemWriteD),
        .JumpD(JumpD), .BranchD(BranchD), .ALUSrcD(ALUSrcD), .ALUControlD(ALUControlD),
        .RD1D(RD1D), .RD2D(RD2D), .PCD(PCD), .PCPlus4D(PCPlus4D), .ImmExtD(ImmExtD),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD),
        .ValidE(ValidE), .RegWriteE(RegWriteE), .ResultSrcE(ResultSrcE),
        .MemWriteE(MemWriteE), .JumpE(JumpE), .BranchE(BranchE), .ALUSrcE(ALUSrcE),
        .ALUControlE(ALUControlE), .RD1E(RD1E), .RD2E(RD2E), .PCE(PCE),
        .PCPlus4E(PCPlus4E), .ImmExtE(ImmExtE), .Rs1E(Rs1E), .Rs2E(Rs2E),
`ifdef IDEX_PERF_CNT_EN
        .RdE(RdE), .StallCntE(StallCntE), .BubbleCntE(BubbleCntE)
`else
        .RdE(RdE)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        StallE = 0; FlushE = 0; ValidD = 1;
        RegWriteD = 0; ResultSrcD = 0; MemWriteD = 0; JumpD = 0; BranchD = 0; ALUSrcD = 0;
        ALUControlD = 0; RD1D = 0; RD2D = 0; PCD = 0; PCPlus4D = 0; ImmExtD = 0;
        Rs1D = 0; Rs2D = 0; RdD = 0;
    endtask

    task automatic test_reset();
        rst_n = 1;
        StallE = 0; FlushE = 0; ValidD = 1;
        RegWriteD = 1; ResultSrcD = 2'b11; MemWriteD = 1; JumpD = 1; BranchD = 1; ALUSrcD = 1;
        ALUControlD = 3'b111; RD1D = '1; RD2D = '1; PCD = '1; PCPlus4D = '1; ImmExtD = '1;
        Rs1D = '1; Rs2D = '1; RdD = '1;
        step();
        total++;
        if (all_e !== {186{1'b1}}) $display("FAIL preload_ones got %h want all ones", all_e);
        else passed++;
        #3 rst_n = 0;
        #1;
        total++;
        if (all_e !== 186'd0) $display("FAIL async_reset got %h want 0", all_e);
        else passed++;
`ifdef IDEX_PERF_CNT_EN
        total++;
        if ({StallCntE, BubbleCntE} !== 8'd0) $display("FAIL reset_counters got %h want 00", {StallCntE, BubbleCntE});
        else passed++;
`endif
        #1 idle_inputs();
        #1 rst_n = 1;
    endtask

    task automatic test_load();
        idle_inputs();
        RegWriteD = 1; ALUSrcD = 1; ResultSrcD = 2'b01; ImmExtD = 32'd8; RdD = 5'd5;
        Rs1D = 5'd2; PCD = 32'h40; PCPlus4D = 32'h44; RD1D = 32'h0000_1000;
        #1;
        total++;
        if (all_e !== 186'd0) $display("FAIL no_comb_path got %h want 0", all_e);
        else passed++;
        step();
        total++;
        if ({ValidE, RegWriteE, ALUSrcE, ResultSrcE, MemWriteE, JumpE, BranchE, ALUControlE} !== 11'b111_01_000_000)
            $display("FAIL load_ctrl got %b want 11101000000",
                     {ValidE, RegWriteE, ALUSrcE, ResultSrcE, MemWriteE, JumpE, BranchE, ALUControlE});
        else passed++;
        total++;
        if ({PCE, PCPlus4E, ImmExtE, RD1E, RdE, Rs1E} !== {32'h40, 32'h44, 32'd8, 32'h1000, 5'd5, 5'd2})
            $display("FAIL load_data got pc=%h pc4=%h imm=%h rd1=%h rd=%0d rs1=%0d want 40 44 8 1000 5 2",
                     PCE, PCPlus4E, ImmExtE, RD1E, RdE, Rs1E);
        else passed++;
    endtask

    task automatic test_stall();
        idle_inputs();
        PCD = 32'h44; RegWriteD = 1;
        step();
        StallE = 1; PCD = 32'h48; RegWriteD = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            total++;
            if (PCE !== 32'h44 || RegWriteE !== 1'b1)
                $display("FAIL stall_hold_%0d got pc=%h rw=%b want 44 1", i, PCE, RegWriteE);
            else passed++;
        end
`ifdef IDEX_PERF_CNT_EN
        total++;
        if (StallCntE !== 4'd3) $display("FAIL stall_count got %0d want 3", StallCntE);
        else passed++;
`endif
        StallE = 0;
    endtask

    task automatic test_flush();
        idle_inputs();
        MemWriteD = 1; ALUSrcD = 1; RD2D = 32'h1234; PCD = 32'h50; FlushE = 1;
        step();
        total++;
        if (MemWriteE !== 1'b0 || ValidE !== 1'b0 || PCE !== 32'h0 || all_e !== 186'd0)
            $display("FAIL flush_bubble got %h want 0", all_e);
        else passed++;
`ifdef IDEX_PERF_CNT_EN
        total++;
        if (BubbleCntE !== 4'd1) $display("FAIL flush_count got %0d want 1", BubbleCntE);
        else passed++;
`endif
    endtask

    task automatic test_flush_stall();
        idle_inputs();
        PCD = 32'h58; RD1D = 32'h77;
        step();
        JumpD = 1; RegWriteD = 1; ResultSrcD = 2'b10; PCD = 32'h60; StallE = 1; FlushE = 1;
        step();
        total++;
        if (all_e !== 186'd0) $display("FAIL flush_stall_bubble got %h want 0", all_e);
        else passed++;
`ifdef IDEX_PERF_CNT_EN
        total++;
        if ({StallCntE, BubbleCntE} !== {4'd3, 4'd2})
            $display("FAIL flush_stall_counts got stall=%0d bub=%0d want 3 2", StallCntE, BubbleCntE);
        else passed++;
`endif
    endtask

    task automatic test_invalid();
        idle_inputs();
        ValidD = 0; RegWriteD = 1; BranchD = 1; ALUControlD = 3'b101; RD1D = 32'hdead; PCD = 32'h70;
        step();
        total++;
        if ({ValidE, RegWriteE, BranchE, ALUControlE} !== 6'd0)
            $display("FAIL invalid_ctrl got %b want 000000", {ValidE, RegWriteE, BranchE, ALUControlE});
        else passed++;
        total++;
        if (RD1E !== 32'hdead || PCE !== 32'h70)
            $display("FAIL invalid_data got rd1=%h pc=%h want dead 70", RD1E, PCE);
        else passed++;
`ifdef IDEX_PERF_CNT_EN
        total++;
        if (BubbleCntE !== 4'd3) $display("FAIL invalid_count got %0d want 3", BubbleCntE);
        else passed++;
`endif
    endtask

    task automatic test_saturation();
        idle_inputs();
        PCD = 32'h80;
        step();
        StallE = 1; PCD = 32'h84;
        for (int i = 0; i < 20; i++) step();
        total++;
        if (PCE !== 32'h80) $display("FAIL long_stall_hold got %h want 80", PCE);
        else passed++;
`ifdef IDEX_PERF_CNT_EN
        total++;
        if (StallCntE !== 4'd15) $display("FAIL stall_saturate got %0d want 15", StallCntE);
        else passed++;
        step();
        total++;
        if (StallCntE !== 4'd15) $display("FAIL stall_saturate_hold got %0d want 15", StallCntE);
        else passed++;
`endif
        StallE = 0;
    endtask

    task automatic test_back_to_back();
        logic [31:0] pcs [4];
        pcs[0] = 32'h100; pcs[1] = 32'h104; pcs[2] = 32'h108; pcs[3] = 32'h10c;
        idle_inputs();
        for (int i = 0; i < 4; i++) begin
            PCD = pcs[i]; PCPlus4D = pcs[i] + 32'd4; RdD = 5'(i + 1); BranchD = i[0];
            step();
            total++;
            if (PCE !== pcs[i] || PCPlus4E !== pcs[i] + 32'd4 || RdE !== 5'(i + 1) || BranchE !== i[0] || ValidE !== 1'b1)
                $display("FAIL b2b_%0d got pc=%h pc4=%h rd=%0d br=%b v=%b", i, PCE, PCPlus4E, RdE, BranchE, ValidE);
            else passed++;
        end
    endtask

    initial begin
        passed = 0;
        total  = 0;
        test_reset();
        test_load();
        test_stall();
        test_flush();
        test_flush_stall();
        test_invalid();
        test_saturation();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
